// File: rtl/param_instruction_fetch.sv
// Fetch unit: program store + PC, presents {opcode, operand} pairs to decode.
// Latency: start -> FETCH after one edge, first pair valid one edge later.
// Backpressure: payload holds while valid & !ready; stall freezes everything.
module param_instruction_fetch #(
    parameter int WORD_W = 3,
    parameter int DEPTH  = 16,
    parameter int PTR_W  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                load_en,
    input  logic [PTR_W-1:0]    load_addr,
    input  logic [WORD_W-1:0]   load_data,
    input  logic                len_en,
    input  logic [PTR_W:0]      load_len,
    input  logic                start,
    input  logic                jump_en,
    input  logic [PTR_W-1:0]    jump_target,
    input  logic                ready,
    output logic                valid,
    output logic [WORD_W-1:0]   opcode,
    output logic [WORD_W-1:0]   operand,
    output logic [PTR_W-1:0]    instr_pc,
    output logic                busy,
    output logic                done
);

    localparam int LEN_W = PTR_W + 1;
    localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);

    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_FETCH  = 2'b01;
    localparam logic [1:0] ST_HALTED = 2'b10;

    logic [1:0]        state;
    // PC carries one extra bit so stepping past the last pair never wraps to 0.
    logic [LEN_W-1:0]  pc;
    logic [LEN_W-1:0]  len;
    logic [WORD_W-1:0] mem [DEPTH];

    logic [LEN_W-1:0]  pc_plus1;
    logic              pair_exists;
    logic [PTR_W-1:0]  rd_addr0;
    logic [PTR_W-1:0]  rd_addr1;
    logic [LEN_W-1:0]  len_clamped;

    // Pair lookup: a pair exists only when both words at PC and PC+1 lie within len.
    always_comb begin
        pc_plus1    = pc + LEN_W'(1);
        pair_exists = (pc_plus1 < len);
        rd_addr0    = pc[PTR_W-1:0];
        rd_addr1    = pc_plus1[PTR_W-1:0];
        len_clamped = (load_len > DEPTH_L) ? DEPTH_L : load_len;
    end

    // Main sequencer: loads in IDLE, pair fetch and redirect in FETCH, restart from HALTED.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            pc       <= '0;
            len      <= '0;
            valid    <= 1'b0;
            opcode   <= '0;
            operand  <= '0;
            instr_pc <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (!stall) begin
            case (state)
                ST_IDLE: begin
                    if (load_en) begin
                        mem[load_addr] <= load_data;
                    end
                    if (len_en) begin
                        len <= len_clamped;
                    end
                    if (start) begin
                        state <= ST_FETCH;
                        pc    <= '0;
                    end
                end
                ST_FETCH: begin
                    if (jump_en) begin
                        // Redirect discards the presented pair; one bubble follows.
                        pc    <= {1'b0, jump_target};
                        valid <= 1'b0;
                    end else if (!valid || ready) begin
                        if (pair_exists) begin
                            opcode   <= mem[rd_addr0];
                            operand  <= mem[rd_addr1];
                            instr_pc <= rd_addr0;
                            valid    <= 1'b1;
                            pc       <= pc + LEN_W'(2);
                        end else begin
                            valid <= 1'b0;
                            state <= ST_HALTED;
                        end
                    end
                end
                ST_HALTED: begin
                    if (start) begin
                        state <= ST_FETCH;
                        pc    <= '0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Status flags decoded straight from the state register.
    always_comb begin
        busy = (state == ST_FETCH);
        done = (state == ST_HALTED);
    end

endmodule

// File: tb/tb_param_instruction_fetch.sv
module tb_param_instruction_fetch;

    logic       clk;
    logic       rst;
    logic       stall;
    logic       load_en;
    logic [3:0] load_addr;
    logic [2:0] load_data;
    logic       len_en;
    logic [4:0] load_len;
    logic       start;
    logic       jump_en;
    logic [3:0] jump_target;
    logic       ready;
    logic       valid;
    logic [2:0] opcode;
    logic [2:0] operand;
    logic [3:0] instr_pc;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    param_instruction_fetch #(
        .WORD_W(3),
        .DEPTH (16),
        .PTR_W (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .load_en    (load_en),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .len_en     (len_en),
        .load_len   (load_len),
        .start      (start),
        .jump_en    (jump_en),
        .jump_target(jump_target),
        .ready      (ready),
        .valid      (valid),
        .opcode     (opcode),
        .operand    (operand),
        .instr_pc   (instr_pc),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic ev, input logic [2:0] eop,
                       input logic [2:0] eopd, input logic [3:0] epc,
                       input logic eb, input logic ed);
        logic [12:0] obs;
        logic [12:0] exp;
        obs = {valid, opcode, operand, instr_pc, busy, done};
        exp = {ev, eop, eopd, epc, eb, ed};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed v/op/opd/pc/busy/done=%b required %b", tag, obs, exp);
        end
    endtask

    task automatic load_word(input logic [3:0] a, input logic [2:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        tick();
        load_en   = 1'b0;
    endtask

    task automatic set_len(input logic [4:0] l);
        len_en   = 1'b1;
        load_len = l;
        tick();
        len_en   = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
        len_en = 1'b0; load_len = '0; start = 1'b0; jump_en = 1'b0;
        jump_target = '0; ready = 1'b1;
        tick();
        tick();
        chk("reset", 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        tick();

        // Basic run: 2,4,1,5,7,5,0,3 len 8
        load_word(0, 2); load_word(1, 4); load_word(2, 1); load_word(3, 5);
        load_word(4, 7); load_word(5, 5); load_word(6, 0); load_word(7, 3);
        set_len(8);
        chk("idle_after_load", 0, 0, 0, 0, 0, 0);
        pulse_start();
        chk("basic_fetch_entry", 0, 0, 0, 0, 1, 0);
        tick(); chk("basic_p0", 1, 2, 4, 0, 1, 0);
        tick(); chk("basic_p2", 1, 1, 5, 2, 1, 0);
        tick(); chk("basic_p4", 1, 7, 5, 4, 1, 0);
        tick(); chk("basic_p6", 1, 0, 3, 6, 1, 0);
        tick(); chk("basic_halt", 0, 0, 3, 6, 0, 1);

        // Backpressure on (1,5)@2
        pulse_start();
        chk("bp_entry", 0, 0, 3, 6, 1, 0);
        tick(); chk("bp_p0", 1, 2, 4, 0, 1, 0);
        tick(); chk("bp_p2", 1, 1, 5, 2, 1, 0);
        ready = 1'b0;
        tick(); chk("bp_hold1", 1, 1, 5, 2, 1, 0);
        tick(); chk("bp_hold2", 1, 1, 5, 2, 1, 0);
        tick(); chk("bp_hold3", 1, 1, 5, 2, 1, 0);
        ready = 1'b1;
        tick(); chk("bp_p4", 1, 7, 5, 4, 1, 0);
        tick(); chk("bp_p6", 1, 0, 3, 6, 1, 0);
        tick(); chk("bp_halt", 0, 0, 3, 6, 0, 1);

        // Jump: 0,3,5,4,3,0 len 6, jump to 0 on (3,0)@4
        do_reset();
        load_word(0, 0); load_word(1, 3); load_word(2, 5);
        load_word(3, 4); load_word(4, 3); load_word(5, 0);
        set_len(6);
        pulse_start();
        chk("jmp_entry", 0, 0, 0, 0, 1, 0);
        tick(); chk("jmp_p0", 1, 0, 3, 0, 1, 0);
        tick(); chk("jmp_p2", 1, 5, 4, 2, 1, 0);
        tick(); chk("jmp_p4", 1, 3, 0, 4, 1, 0);
        jump_en = 1'b1; jump_target = 4'd0;
        tick(); chk("jmp_bubble", 0, 3, 0, 4, 1, 0);
        jump_en = 1'b0;
        tick(); chk("jmp_p0_again", 1, 0, 3, 0, 1, 0);
        tick(); chk("jmp_p2_again", 1, 5, 4, 2, 1, 0);
        tick(); chk("jmp_p4_again", 1, 3, 0, 4, 1, 0);
        tick(); chk("jmp_halt", 0, 3, 0, 4, 0, 1);

        // Odd length: 2,4,1,5,7 len 5
        do_reset();
        load_word(0, 2); load_word(1, 4); load_word(2, 1);
        load_word(3, 5); load_word(4, 7);
        set_len(5);
        pulse_start();
        chk("odd_entry", 0, 0, 0, 0, 1, 0);
        tick(); chk("odd_p0", 1, 2, 4, 0, 1, 0);
        tick(); chk("odd_p2", 1, 1, 5, 2, 1, 0);
        tick(); chk("odd_halt", 0, 1, 5, 2, 0, 1);
        pulse_start();
        chk("odd_restart", 0, 1, 5, 2, 1, 0);
        jump_en = 1'b1; jump_target = 4'd4;
        tick(); chk("odd_jump4", 0, 1, 5, 2, 1, 0);
        jump_en = 1'b0;
        tick(); chk("odd_jump4_halt", 0, 1, 5, 2, 0, 1);
        pulse_start();
        chk("odd_restart2", 0, 1, 5, 2, 1, 0);
        tick(); chk("odd_restart_p0", 1, 2, 4, 0, 1, 0);

        // Stall for 4 cycles with start/jump asserted (must be ignored)
        stall = 1'b1; start = 1'b1; jump_en = 1'b1; jump_target = 4'd3;
        for (int i = 0; i < 4; i++) begin
            tick(); chk("stall_hold", 1, 2, 4, 0, 1, 0);
        end
        stall = 1'b0; start = 1'b0; jump_en = 1'b0;
        tick(); chk("stall_resume_p2", 1, 1, 5, 2, 1, 0);
        // Loads during FETCH must be ignored
        load_en = 1'b1; load_addr = 4'd0; load_data = 3'd6;
        len_en = 1'b1; load_len = 5'd2;
        tick(); chk("fetch_load_halt", 0, 1, 5, 2, 0, 1);
        load_en = 1'b0; len_en = 1'b0;
        pulse_start();
        chk("readback_entry", 0, 1, 5, 2, 1, 0);
        tick(); chk("readback_p0", 1, 2, 4, 0, 1, 0);
        tick(); chk("readback_p2", 1, 1, 5, 2, 1, 0);
        tick(); chk("readback_halt", 0, 1, 5, 2, 0, 1);

        // Async reset mid-FETCH with valid high
        pulse_start();
        tick(); chk("pre_rst_p0", 1, 2, 4, 0, 1, 0);
        rst = 1'b1;
        #1;
        chk("async_rst", 0, 0, 0, 0, 0, 0);
        tick();
        rst = 1'b0;
        tick();
        // Oversized length clamps to 16; memory reads back all zeros
        set_len(5'd20);
        pulse_start();
        chk("zero_entry", 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 8; i++) begin
            tick(); chk("zero_pair", 1, 0, 0, 4'(2 * i), 1, 0);
        end
        tick(); chk("zero_halt_clamp", 0, 0, 0, 14, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
